// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: locks one requester onto a shared valid/ready channel
// from grant until its last beat is accepted, with a one-cycle bubble between bursts.

// Onehot-select word mux; a zero select yields a zero word.
module rr_burst_arbiter_onehot_mux #(
    parameter int Count = 4,
    parameter int Width = 32
) (
    input  logic [Count-1:0] sel_i,
    input  logic [Width-1:0] data_i [Count],
    output logic [Width-1:0] data_o
);

    // OR together every word whose select bit is set
    always_comb begin
        data_o = '0;
        for (int k = 0; k < Count; k++) begin
            if (sel_i[k]) begin
                data_o = data_o | data_i[k];
            end else begin
                data_o = data_o;
            end
        end
    end

endmodule

module rr_burst_arbiter #(
    parameter int Count = 4,
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Count-1:0] valid_i,
    input  logic [Count-1:0] last_i,
    input  logic [Width-1:0] data_i [Count],
    output logic [Count-1:0] ready_o,
    output logic             valid_o,
    output logic             last_o,
    output logic [Width-1:0] data_o,
    input  logic             ready_i,
    output logic [Count-1:0] grant_o,
    output logic             busy_o
);

    localparam int PtrW = (Count > 1) ? $clog2(Count) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(Count - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [Count-1:0]  grant_q, grant_d;
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [PtrW-1:0]   gidx_q, gidx_d;
    logic [PtrW-1:0]   idx_s;
    logic [PtrW-1:0]   winner_s;
    logic              found_s;
    logic              valid_s;
    logic              last_s;
    logic              release_s;

    // Rotating search starting at ptr; the wrap compares against Count-1 so
    // non-power-of-two counts never visit an out-of-range index.
    always_comb begin
        idx_s    = ptr_q;
        winner_s = '0;
        found_s  = 1'b0;
        for (int i = 0; i < Count; i++) begin
            if (!found_s && valid_i[idx_s]) begin
                found_s  = 1'b1;
                winner_s = idx_s;
            end else begin
                found_s  = found_s;
            end
            idx_s = (idx_s == LastIdx) ? '0 : idx_s + PtrW'(1);
        end
    end

    // Downstream channel is steered purely by the registered grant
    always_comb begin
        valid_s   = |(grant_q & valid_i);
        last_s    = |(grant_q & valid_i & last_i);
        release_s = valid_s && ready_i && last_s;
    end

    rr_burst_arbiter_onehot_mux #(
        .Count (Count),
        .Width (Width)
    ) u_mux (
        .sel_i  (grant_q),
        .data_i (data_i),
        .data_o (data_o)
    );

    // Next-state logic for the IDLE/LOCKED burst FSM
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d           = LOCKED;
                    grant_d           = '0;
                    grant_d[winner_s] = 1'b1;
                    gidx_d            = winner_s;
                end else begin
                    grant_d = '0;
                end
            end
            LOCKED: begin
                if (release_s) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == LastIdx) ? '0 : gidx_q + PtrW'(1);
                end else begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant and pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

    assign valid_o = valid_s;
    assign last_o  = last_s;
    assign ready_o = grant_q & {Count{ready_i}};
    assign grant_o = grant_q;
    assign busy_o  = (state_q == LOCKED);

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter: a 4x32 instance for the burst scenarios
// and a 1x8 instance for back-to-back single-beat bursts.
module tb_rr_burst_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  valid;
    logic [N-1:0]  last;
    logic [W-1:0]  data [N];
    logic [N-1:0]  ready_o;
    logic          valid_o;
    logic          last_o;
    logic [W-1:0]  data_o;
    logic          ready_in;
    logic [N-1:0]  grant_o;
    logic          busy_o;

    logic [0:0]    valid1;
    logic [0:0]    last1;
    logic [7:0]    data1 [1];
    logic [0:0]    ready1_o;
    logic          valid1_o;
    logic          last1_o;
    logic [7:0]    data1_o;
    logic          ready1;
    logic [0:0]    grant1_o;
    logic          busy1_o;

    int checks = 0;
    int errors = 0;

    rr_burst_arbiter #(.Count(N), .Width(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid),
        .last_i  (last),
        .data_i  (data),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .last_o  (last_o),
        .data_o  (data_o),
        .ready_i (ready_in),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    rr_burst_arbiter #(.Count(1), .Width(8)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid1),
        .last_i  (last1),
        .data_i  (data1),
        .ready_o (ready1_o),
        .valid_o (valid1_o),
        .last_o  (last1_o),
        .data_o  (data1_o),
        .ready_i (ready1),
        .grant_o (grant1_o),
        .busy_o  (busy1_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks every output of the 4-requester instance; busy is implied by grant.
    task automatic e(input string tag, input logic [3:0] g, input logic v, input logic l,
                     input logic [3:0] r, input logic [31:0] d);
        chk({tag, " grant"}, 64'(grant_o), 64'(g));
        chk({tag, " busy"},  64'(busy_o),  64'(|g));
        chk({tag, " valid"}, 64'(valid_o), 64'(v));
        chk({tag, " last"},  64'(last_o),  64'(l));
        chk({tag, " ready"}, 64'(ready_o), 64'(r));
        chk({tag, " data"},  64'(data_o),  64'(d));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] oh;
        int         xfers;

        rst      = 1'b1;
        valid    = 4'b0000;
        last     = 4'b0000;
        ready_in = 1'b0;
        valid1   = 1'b0;
        last1    = 1'b0;
        ready1   = 1'b0;
        data1[0] = 8'h5A;
        for (int k = 0; k < N; k++) data[k] = 32'(k + 1) * 32'h1111_1111 + 32'h0000_00A0;
        tick();
        tick();
        #2 e("reset", 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0);
        chk("reset grant1", 64'(grant1_o), 64'h0);
        rst = 1'b0;

        // Single-beat burst from requester 2
        valid = 4'b0100; last = 4'b0100; ready_in = 1'b1;
        #2 e("t1 idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0);
        tick();
        #2 e("t1 grant2", 4'b0100, 1'b1, 1'b1, 4'b0100, data[2]);
        tick();
        valid = 4'b1111; last = 4'b0000;
        #2 e("t1 release", 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0);
        tick();
        // ptr is now 3, so requester 3 wins among all four
        #2 e("t1 ptr3", 4'b1000, 1'b1, 1'b0, 4'b1000, data[3]);
        last = 4'b1000;
        #2 e("t1 last3", 4'b1000, 1'b1, 1'b1, 4'b1000, data[3]);
        tick();

        // Four requesters with 3-beat bursts from ptr 0: order 0,1,2,3,0
        for (int b = 0; b < 5; b++) begin
            oh   = 4'b0001 << (b % 4);
            last = 4'b0000;
            #2 e("t2 bubble", 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0);
            tick();
            for (int t = 0; t < 3; t++) begin
                last = (t == 2) ? oh : 4'b0000;
                #2 e("t2 beat", oh, 1'b1, (t == 2), oh, data[b % 4]);
                tick();
            end
        end

        // Requester 1 with downstream stall (ptr = 1)
        valid = 4'b0010; last = 4'b0000;
        #2 e("t3 idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0);
        tick();
        #2 e("t3 beat0", 4'b0010, 1'b1, 1'b0, 4'b0010, data[1]);
        tick();
        ready_in = 1'b0;
        for (int s = 0; s < 2; s++) begin
            #2 e("t3 stall", 4'b0010, 1'b1, 1'b0, 4'b0000, data[1]);
            tick();
        end
        ready_in = 1'b1; last = 4'b0010;
        #2 e("t3 last", 4'b0010, 1'b1, 1'b1, 4'b0010, data[1]);
        tick();

        // Requester 3 drops valid mid-burst while requester 0 waits (ptr = 2)
        valid = 4'b1001; last = 4'b0000;
        #2 e("t4 idle", 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0);
        tick();
        #2 e("t4 grant3", 4'b1000, 1'b1, 1'b0, 4'b1000, data[3]);
        tick();
        valid = 4'b0001;
        for (int s = 0; s < 2; s++) begin
            #2 e("t4 drop", 4'b1000, 1'b0, 1'b0, 4'b1000, data[3]);
            tick();
        end
        valid = 4'b1001; last = 4'b1000;
        #2 e("t4 last", 4'b1000, 1'b1, 1'b1, 4'b1000, data[3]);
        tick();
        valid = 4'b0001; last = 4'b0000;
        #2 e("t4 bubble", 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0);
        tick();
        last = 4'b0001;
        #2 e("t4 grant0", 4'b0001, 1'b1, 1'b1, 4'b0001, data[0]);
        tick();

        // Move ptr to 2, then reset in the middle of requester 2's burst
        valid = 4'b0010; last = 4'b0010;
        tick();
        #2 e("t5 grant1", 4'b0010, 1'b1, 1'b1, 4'b0010, data[1]);
        tick();
        valid = 4'b0100; last = 4'b0000;
        tick();
        #2 e("t5 grant2", 4'b0100, 1'b1, 1'b0, 4'b0100, data[2]);
        tick();
        rst = 1'b1;
        tick();
        #2 e("t5 reset", 4'b0000, 1'b0, 1'b0, 4'b0000, 32'h0);
        rst = 1'b0; valid = 4'b0110;
        tick();
        // With ptr reset to 0 requester 1 wins; a stale ptr of 2 would pick 2
        #2 e("t5 winner1", 4'b0010, 1'b1, 1'b0, 4'b0010, data[1]);
        valid = 4'b0000;

        // Count = 1: continuous single-beat bursts
        valid1 = 1'b1; last1 = 1'b1; ready1 = 1'b1;
        xfers  = 0;
        for (int c = 0; c < 8; c++) begin
            #2 chk("t6 grant1", 64'(grant1_o), 64'(c % 2));
            chk("t6 valid1", 64'(valid1_o), 64'(c % 2));
            chk("t6 data1", 64'(data1_o), (c % 2 == 1) ? 64'h5A : 64'h0);
            if (valid1_o && ready1) xfers++;
            tick();
        end
        chk("t6 xfers", 64'(xfers), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
